// File: rtl/seg_count_ctrl.sv
// Four-digit hex up/down counter with a multiplexed seven-segment scan.
// Optional leading-zero blanking is built when SEG_BLANK_EN is defined.
module seg_count_ctrl #(
   parameter int TICK_DIV = 25000000,
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mode,
   input  logic        run,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [3:0]  com,
   output logic [6:0]  segment,
   output logic        step,
   output logic [15:0] count
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

   logic [PW-1:0] p_q, p_d;
   logic [SW-1:0] s_q, s_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          step_q, step_d;
   logic [3:0]    com_q, com_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    nib;
   logic          blank;

   // Count path: load wins over a due step and keeps the prescaler cleared.
   always_comb begin
      p_d    = p_q;
      cnt_d  = cnt_q;
      step_d = 1'b0;
      if (load) begin
         cnt_d = load_val;
         p_d   = '0;
      end else if (run) begin
         if (p_q == P_LAST) begin
            p_d    = '0;
            step_d = 1'b1;
            cnt_d  = mode ? cnt_q - 16'd1 : cnt_q + 16'd1;
         end else begin
            p_d = p_q + 1'b1;
         end
      end
   end

   always_comb begin
      s_d   = s_q + 1'b1;
      idx_d = idx_q;
      if (s_q == S_LAST) begin
         s_d   = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   always_comb begin
      nib   = cnt_q[3:0];
      blank = 1'b0;
      case (idx_q)
         2'd0: nib = cnt_q[3:0];
         2'd1: nib = cnt_q[7:4];
         2'd2: nib = cnt_q[11:8];
         default: nib = cnt_q[15:12];
      endcase
`ifdef SEG_BLANK_EN
      case (idx_q)
         2'd1: blank = (cnt_q[15:4] == 12'd0);
         2'd2: blank = (cnt_q[15:8] == 8'd0);
         2'd3: blank = (cnt_q[15:12] == 4'd0);
         default: blank = 1'b0;
      endcase
`endif
   end

   always_comb begin
      case (nib)
         4'h0: seg_d = 7'b0111111;
         4'h1: seg_d = 7'b0000110;
         4'h2: seg_d = 7'b1011011;
         4'h3: seg_d = 7'b1001111;
         4'h4: seg_d = 7'b1100110;
         4'h5: seg_d = 7'b1101101;
         4'h6: seg_d = 7'b1111101;
         4'h7: seg_d = 7'b0000111;
         4'h8: seg_d = 7'b1111111;
         4'h9: seg_d = 7'b1101111;
         4'hA: seg_d = 7'b1110111;
         4'hB: seg_d = 7'b1111100;
         4'hC: seg_d = 7'b1011000;
         4'hD: seg_d = 7'b1011110;
         4'hE: seg_d = 7'b1111001;
         default: seg_d = 7'b1110001;
      endcase
      if (blank) seg_d = 7'b0000000;
      com_d = ~(4'b0001 << idx_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q    <= '0;
         s_q    <= '0;
         idx_q  <= 2'd0;
         cnt_q  <= 16'd0;
         step_q <= 1'b0;
         com_q  <= 4'b1111;
         seg_q  <= 7'b0000000;
      end else begin
         p_q    <= p_d;
         s_q    <= s_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         step_q <= step_d;
         com_q  <= com_d;
         seg_q  <= seg_d;
      end
   end

   assign com     = com_q;
   assign segment = seg_q;
   assign step    = step_q;
   assign count   = cnt_q;

endmodule

// File: doc/seg_count_ctrl.md
# seg_count_ctrl

Sequencing controller for the board's seven-segment display. Holds a 4-digit hexadecimal up/down counter (0x0000–0xFFFF), steps it from a prescaled tick, and time-multiplexes one shared hex-to-segment decoder across four common-cathode digits. Sits between board switches (mode/run/load) and the display pins, replacing the single-digit free-running counter.

## Interface
- `TICK_DIV`, 25000000: clk cycles per count step; must be ≥ 2.
- `SCAN_DIV`, 50000: clk cycles each digit is lit; must be ≥ 2.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `mode` in 1: count direction; 0 = up, 1 = down.
- `run` in 1: 1 = prescaler advances; 0 = pause, holding prescaler and count.
- `load` in 1: synchronous load request, level-sampled each cycle.
- `load_val` in 16: value loaded into the count when `load`=1.
- `com` out 4: digit enables, active-low, one-hot-low; bit 0 = rightmost digit.
- `segment` out 7: segments {g,f,e,d,c,b,a}, active-high.
- `step` out 1: one-cycle pulse marking a count step.
- `count` out 16: current count value.

## Operation
- Step prescaler `p`, counting 0..TICK_DIV-1:
  - Advances only while `run`=1.
  - At `p`=TICK_DIV-1 with `run`=1, the same edge sets `p`←0 and steps the count: +1 if `mode`=0, −1 if `mode`=1.
  - `mode` is sampled on that edge only.
- Count wraps modulo 2^16: up from 0xFFFF gives 0x0000; down from 0x0000 gives 0xFFFF.
- `load`=1 has priority over a step on the same edge:
  - count←`load_val`, `p`←0, `step` stays 0.
  - Holding `load` keeps the prescaler cleared, so no step occurs while `load` is high.
- `step` is registered. It is 1 during exactly the cycle in which `count` first shows the stepped value.
- Scan prescaler `s`, counting 0..SCAN_DIV-1:
  - Runs freely, independent of `run` and `load`.
  - At terminal count, digit index `idx` (2 bits) increments, wrapping 3→0.
- Registered outputs, updated every cycle:
  - `com` ← all ones with bit `idx` cleared.
  - `segment` ← decode(count nibble `idx`).
- Decode table (0–F):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - c=1011000, d=1011110, E=1111001, F=1110001
- Exactly one `com` bit is low in every cycle after the first post-reset edge. The digit's `com` and `segment` always change on the same edge, so no ghosting.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - count=0, `p`=0, `s`=0, `idx`=0
  - `step`=0, `com`=4'b1111 (all digits dark), `segment`=7'b0000000
- Reset mid-step or mid-scan discards all progress. No step is emitted on the reset edge.
- First edge after reset release: `com`=4'b1110, `segment`=7'b0111111.
- Step latency:
  - With `run` held at 1, the first step lands TICK_DIV edges after reset release or load.
  - Steady-state step period is TICK_DIV cycles.
- Load latency: `count` shows `load_val` on the edge after `load` is sampled. The displayed digit follows one edge later.
- Dwell: each digit is lit for exactly SCAN_DIV cycles. A full frame is 4×SCAN_DIV cycles.
- Pause: deasserting `run` freezes `p`. Re-asserting resumes from the frozen value, so the partial interval is kept.

## Configuration
- `SEG_BLANK_EN` defined: leading-zero blanking.
  - A digit whose nibble and all more-significant nibbles are 0 drives `segment`=7'b0000000.
  - Digit 0 is never blanked, so 0x0000 shows a single "0".
  - `com` scanning is unchanged.
- `SEG_BLANK_EN` undefined: every digit always shows its nibble, including leading zeros.

## Test plan
All scenarios use TICK_DIV=4, SCAN_DIV=3.
- Reset, then `run`=1, `mode`=0 for 20 cycles → `count` reads 1,2,3,4,5 at edges 4,8,12,16,20; `step` pulses on exactly those cycles.
- `load`=1 with `load_val`=0xFFFE, then `mode`=0 → `count` goes 0xFFFF then 0x0000. Then `mode`=1 → `count` goes 0xFFFF.
- `load` asserted on the same edge a step is due, `load_val`=0x1234 → `count`=0x1234, no `step`; next step arrives 4 edges later.
- `run` dropped for 10 cycles at `p`=2 → `count` and `p` frozen. After re-assert, step after 2 more edges.
- Scan check with `count`=0x00A5 → `com` cycles 1110, 1101, 1011, 0111, each for 3 cycles:
  - without the macro, `segment` shows 1101101, 1110111, 0111111, 0111111;
  - with `SEG_BLANK_EN`, digits 2–3 show 0000000.
- `rst_n` low for one edge mid-frame at `count`=0x0042 → `count`=0, `com`=1111, `segment`=0000000 that cycle; next edge `com`=1110, `segment`=0111111.
